// File: rtl/folded_sram_multiway_pkg.sv
// Shared types and width helpers for the folded multi-way predictor SRAM.
package sram_pkg;

    typedef enum logic {
        INIT,
        IDLE
    } sram_state_e;

    localparam int DEF_SETS  = 128;
    localparam int DEF_WAYS  = 2;
    localparam int DEF_WIDTH = 50;
    localparam int DEF_FOLD  = 2;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int bitw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = bitw(DEF_SETS);
    localparam int DEF_ROW_W = bitw(DEF_SETS / DEF_FOLD);
    localparam int DEF_COL_W = bitw(DEF_FOLD);

    typedef logic [DEF_WIDTH-1:0]          way_entry_t;
    typedef logic [DEF_WAYS*DEF_WIDTH-1:0] way_line_t;

    function automatic way_entry_t get_way(input way_line_t line, input int way);
        return line[way*DEF_WIDTH +: DEF_WIDTH];
    endfunction

    function automatic way_line_t put_way(input way_line_t line, input int way, input way_entry_t entry);
        way_line_t result;
        result = line;
        result[way*DEF_WIDTH +: DEF_WIDTH] = entry;
        return result;
    endfunction

endpackage

// File: rtl/folded_sram_multiway_if.sv
// Request/response bundle between predictor table logic (master) and the SRAM (slave).
interface folded_sram_multiway_if #(
    parameter int SETS  = 128,
    parameter int WAYS  = 2,
    parameter int WIDTH = 50
);
    localparam int IDX_W = sram_pkg::bitw(SETS);

    logic                   rreq_valid;
    logic                   rreq_ready;
    logic [IDX_W-1:0]       rreq_bits_setIdx;
    logic                   rresp_valid;
    logic [WAYS*WIDTH-1:0]  rresp_data;
    logic                   wreq_valid;
    logic                   wreq_ready;
    logic [IDX_W-1:0]       wreq_bits_setIdx;
    logic [WAYS*WIDTH-1:0]  wreq_bits_data;
    logic [WAYS-1:0]        wreq_bits_waymask;

    modport master (
        output rreq_valid, rreq_bits_setIdx,
        output wreq_valid, wreq_bits_setIdx, wreq_bits_data, wreq_bits_waymask,
        input  rreq_ready, rresp_valid, rresp_data, wreq_ready
    );

    modport slave (
        input  rreq_valid, rreq_bits_setIdx,
        input  wreq_valid, wreq_bits_setIdx, wreq_bits_data, wreq_bits_waymask,
        output rreq_ready, rresp_valid, rresp_data, wreq_ready
    );

endinterface

// File: rtl/folded_sram_multiway_array.sv
// Behavioural 1R1W row array: registered read, bit-granular write enable.
module sram_array_1r1w #(
    parameter int ROWS        = 64,
    parameter int ROW_BITS    = 200,
    parameter int AW          = 6,
    parameter bit SINGLE_PORT = 1'b0
) (
    input  logic                clk,
    input  logic                i_ren,
    input  logic [AW-1:0]       i_raddr,
    output logic [ROW_BITS-1:0] o_rdata,
    input  logic                i_wen,
    input  logic [AW-1:0]       i_waddr,
    input  logic [ROW_BITS-1:0] i_wdata,
    input  logic [ROW_BITS-1:0] i_wbitmask
);

    logic [ROW_BITS-1:0] r_mem [ROWS];
    logic [ROW_BITS-1:0] r_rdata;

    // Read returns the row contents from before a same-cycle write; the top handles bypass.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wbitmask) | (i_wdata & i_wbitmask);
        end
        if (i_ren) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

    a_singlePortExclusive: assert property (@(posedge clk) !(SINGLE_PORT && i_ren && i_wen));

endmodule

// File: rtl/folded_sram_multiway.sv
// Folded multi-way SRAM wrapper: init sweep, per-way masked writes, same-set bypass, read hold.
module folded_sram_multiway
    import sram_pkg::*;
#(
    parameter int SETS         = 128,
    parameter int WAYS         = 2,
    parameter int WIDTH        = 50,
    parameter int FOLD         = 2,
    parameter bit SHOULD_RESET = 1'b1,
    parameter bit HOLD_READ    = 1'b1,
    parameter bit SINGLE_PORT  = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    folded_sram_multiway_if.slave   io
);

    localparam int ROWS     = SETS / FOLD;
    localparam int LINE     = WAYS * WIDTH;
    localparam int ROW_BITS = FOLD * LINE;
    localparam int IDX_W    = bitw(SETS);
    localparam int ROW_W    = bitw(ROWS);
    localparam int COL_W    = bitw(FOLD);
    localparam int FOLD_LOG = $clog2(FOLD);

    if ((SETS % FOLD) != 0 || (SETS & (SETS - 1)) != 0 || (FOLD & (FOLD - 1)) != 0) begin : g_badParams
        $error("folded_sram_multiway: SETS and FOLD must be powers of two with FOLD dividing SETS");
    end

    sram_state_e         r_state;
    logic [ROW_W-1:0]    r_initRow;

    logic                w_idle;
    logic                w_init;
    logic                w_rfire;
    logic                w_wfire;
    logic [ROW_W-1:0]    w_rrow;
    logic [COL_W-1:0]    w_rcol;
    logic [ROW_W-1:0]    w_wrow;
    logic [COL_W-1:0]    w_wcol;

    logic                w_arrWen;
    logic [ROW_W-1:0]    w_arrWaddr;
    logic [ROW_BITS-1:0] w_arrWdata;
    logic [ROW_BITS-1:0] w_arrMask;
    logic [ROW_BITS-1:0] w_bitMask;
    logic [ROW_BITS-1:0] w_arrRdata;

    logic                r_rvalid;
    logic [COL_W-1:0]    r_col;
    logic                r_bypHit;
    logic [LINE-1:0]     r_bypData;
    logic [WAYS-1:0]     r_bypMask;
    logic [LINE-1:0]     w_rowLine;
    logic [LINE-1:0]     w_merged;

    // Readies are gated by reset so nothing is accepted in the cycle reset asserts.
    assign w_init          = (r_state == INIT);
    assign w_idle          = (r_state == IDLE) && !reset;
    assign io.wreq_ready   = w_idle;
    assign io.rreq_ready   = w_idle && !(SINGLE_PORT && io.wreq_valid);
    assign w_wfire         = io.wreq_valid && io.wreq_ready;
    assign w_rfire         = io.rreq_valid && io.rreq_ready;

    assign w_rrow = ROW_W'(io.rreq_bits_setIdx >> FOLD_LOG);
    assign w_rcol = COL_W'(io.rreq_bits_setIdx & IDX_W'(FOLD - 1));
    assign w_wrow = ROW_W'(io.wreq_bits_setIdx >> FOLD_LOG);
    assign w_wcol = COL_W'(io.wreq_bits_setIdx & IDX_W'(FOLD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= SHOULD_RESET ? INIT : IDLE;
            r_initRow <= '0;
        end else if (r_state == INIT) begin
            if (r_initRow == ROW_W'(ROWS - 1)) begin
                r_state <= IDLE;
            end
            r_initRow <= r_initRow + 1'b1;
        end
    end

    always_comb begin
        w_bitMask = '0;
        for (int c = 0; c < FOLD; c++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (COL_W'(c) == w_wcol && io.wreq_bits_waymask[w]) begin
                    w_bitMask[(c*WAYS + w)*WIDTH +: WIDTH] = '1;
                end
            end
        end
    end

    // The init sweep owns the write port; normal writes only land in IDLE.
    assign w_arrWen   = w_init || w_wfire;
    assign w_arrWaddr = w_init ? r_initRow : w_wrow;
    assign w_arrWdata = w_init ? '0 : {FOLD{io.wreq_bits_data}};
    assign w_arrMask  = w_init ? '1 : w_bitMask;

    sram_array_1r1w #(
        .ROWS        (ROWS),
        .ROW_BITS    (ROW_BITS),
        .AW          (ROW_W),
        .SINGLE_PORT (SINGLE_PORT)
    ) u_array (
        .clk        (clock),
        .i_ren      (w_rfire),
        .i_raddr    (w_rrow),
        .o_rdata    (w_arrRdata),
        .i_wen      (w_arrWen),
        .i_waddr    (w_arrWaddr),
        .i_wdata    (w_arrWdata),
        .i_wbitmask (w_arrMask)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid  <= 1'b0;
            r_col     <= '0;
            r_bypHit  <= 1'b0;
            r_bypData <= '0;
            r_bypMask <= '0;
        end else begin
            r_rvalid <= w_rfire;
            if (w_rfire) begin
                r_col     <= w_rcol;
                r_bypHit  <= !SINGLE_PORT && w_wfire &&
                             (io.rreq_bits_setIdx == io.wreq_bits_setIdx);
                r_bypData <= io.wreq_bits_data;
                r_bypMask <= io.wreq_bits_waymask;
            end
        end
    end

    // Array read is pre-write, so a same-set write is overlaid per masked way here.
    always_comb begin
        w_rowLine = w_arrRdata[r_col*LINE +: LINE];
        w_merged  = w_rowLine;
        for (int w = 0; w < WAYS; w++) begin
            if (r_bypHit && r_bypMask[w]) begin
                w_merged[w*WIDTH +: WIDTH] = r_bypData[w*WIDTH +: WIDTH];
            end
        end
    end

    assign io.rresp_valid = r_rvalid;

    if (HOLD_READ) begin : g_hold
        logic [LINE-1:0] r_hold;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_hold <= '0;
            end else if (r_rvalid) begin
                r_hold <= w_merged;
            end
        end

        assign io.rresp_data = r_rvalid ? w_merged : r_hold;
    end else begin : g_noHold
        assign io.rresp_data = r_rvalid ? w_merged : '0;
    end

endmodule
